input_port_ctrl: RTL and testbench
==================================

# input_port_ctrl

Polling controller that sequences the 8-bit input port for the CPU. It periodically enables the port, captures the pin value through a two-stage register, and holds the last value. It flags changes with a new-data status and an optional interrupt, and serves CPU reads through a single-cycle request/acknowledge handshake. It sits between the port (enable in, combinational data out) and the CPU IN-instruction path.

## Interface
- WIDTH, 8: port data width.
- POLL_DIV, 4: number of WAIT cycles between polls. Must be ≥1.
- clk  input  1  system clock; all flops rise-edge.
- rst_n  input  1  asynchronous, active-low reset.
- port_en  output  1  enable to the input port; high only in state ENABLE.
- port_data  input  WIDTH  data from the input port; valid while port_en=1, 0 otherwise.
- rd_req  input  1  CPU read request (level).
- rd_ack  output  1  one-cycle read acknowledge.
- rd_data  output  WIDTH  value returned on read; holds between reads.
- irq_en  input  1  interrupt mask.
- irq  output  1  interrupt = new_flag & irq_en (combinational from flops).
- new_flag  output  1  held value changed since last read.
- overrun  output  1  sticky; a change occurred while new_flag was already set.

## Operation
- Internal registers:
  - cnt: poll counter, log2(POLL_DIV) bits minimum.
  - s1, s2: capture stages.
  - held: last accepted value.
- FSM states: WAIT, ENABLE, SYNC, UPDATE.
  - WAIT: cnt counts down from POLL_DIV-1. At cnt==0, go to ENABLE.
  - ENABLE: port_en=1; s1<=port_data; go to SYNC.
  - SYNC: s2<=s1; go to UPDATE.
  - UPDATE: if s2!=held, then held<=s2 and the change event fires. Go to WAIT with cnt<=POLL_DIV-1.
- Poll period is exactly POLL_DIV+3 cycles. An unchanged value produces no event.
- Change event (UPDATE edge with s2!=held):
  - new_flag<=1.
  - overrun<=1 if new_flag was 1 and no read is accepted on the same edge.
- Read acceptance edge: rising edge with rd_req=1 and rd_ack=0.
  - rd_ack<=1 for one cycle.
  - rd_data<=held, the pre-update value if an update occurs on the same edge.
  - new_flag<=0 and overrun<=0, unless a change event occurs on the same edge. In that case new_flag<=1 and overrun<=0.
- rd_req held high gives an acknowledge every second cycle. No acknowledge is issued while rd_ack=1.
- Reads are independent of FSM state; polling never stalls.
- Reset (asynchronous, any time, including mid-poll or mid-handshake):
  - state=WAIT, cnt=POLL_DIV-1.
  - s1, s2, held, rd_data = 0.
  - port_en, rd_ack, new_flag, overrun, irq = 0.

## Timing
- Cycle 0 is the first rising edge after rst_n deasserts.
- Cycles 0..POLL_DIV-1 are WAIT. ENABLE is at cycle POLL_DIV (port_en high for that cycle only). SYNC is at POLL_DIV+1 and UPDATE at POLL_DIV+2.
- new_flag and irq are visible from cycle POLL_DIV+3.
- Pin-to-flag latency after port_en: 3 edges. Pin changes outside ENABLE are ignored until the next poll.
- Read latency: rd_ack and rd_data are valid the cycle after the acceptance edge. new_flag drops in that same cycle.
- irq follows new_flag and irq_en with zero added latency.
- port_data is sampled only at the ENABLE edge. A glitch at any other time must not affect held.

## Test plan
- Reset then poll, POLL_DIV=4, pins=0xA5:
  - port_en high in cycle 4 only.
  - new_flag=1 from cycle 7.
  - irq=1 with irq_en=1; irq=0 with irq_en=0.
- Read handshake: after the poll above, pulse rd_req for one cycle.
  - rd_ack one cycle later with rd_data=0xA5.
  - new_flag and irq go to 0.
  - A second poll with unchanged pins leaves new_flag=0.
- Overrun:
  - pins 0xA5, then 0x3C before any read: overrun=1, held=0x3C.
  - The next read returns 0x3C and clears overrun and new_flag.
- Simultaneous events: align the rd_req acceptance edge with an UPDATE edge where pins change 0x3C→0x81.
  - rd_data=0x3C.
  - new_flag stays 1, overrun=0.
  - The next read returns 0x81.
- Continuous rd_req for 6 cycles: rd_ack toggles 0,1,0,1,... with no back-to-back acknowledges.
- Reset mid-operation: assert rst_n=0 during SYNC and during rd_ack=1.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, the first port_en occurs exactly POLL_DIV cycles later.

Source files
------------

// File: rtl/input_port_ctrl.sv
// Polling controller for an 8-bit input port: periodic enable, two-stage capture,
// change/overrun status and a single-cycle CPU read handshake.
module input_port_ctrl #(
    parameter int WIDTH    = 8,
    parameter int POLL_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             port_en,
    input  logic [WIDTH-1:0] port_data,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [WIDTH-1:0] rd_data,
    input  logic             irq_en,
    output logic             irq,
    output logic             new_flag,
    output logic             overrun
);
    localparam int               CNT_W      = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(POLL_DIV - 1);

    typedef enum logic [1:0] {WAIT, ENABLE, SYNC, UPDATE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_held;
    logic             r_rd_ack;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_new_flag;
    logic             r_overrun;
    logic             w_port_en;
    logic             w_change;
    logic             w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_port_en   = 1'b0;
        case (r_state)
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ENABLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ENABLE: begin
                w_port_en   = 1'b1;
                w_state_nxt = SYNC;
            end
            SYNC: begin
                w_state_nxt = UPDATE;
            end
            UPDATE: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = CNT_RELOAD;
            end
            default: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = CNT_RELOAD;
            end
        endcase
    end

    // A change event only fires on the UPDATE edge; the ack register blocks back-to-back reads.
    assign w_change = (r_state == UPDATE) && (r_s2 != r_held);
    assign w_accept = rd_req && !r_rd_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT;
            r_cnt   <= CNT_RELOAD;
            r_s1    <= '0;
            r_s2    <= '0;
            r_held  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == ENABLE) begin
                r_s1 <= port_data;
            end
            if (r_state == SYNC) begin
                r_s2 <= r_s1;
            end
            if (w_change) begin
                r_held <= r_s2;
            end
        end
    end

    // A read on the same edge as a change returns the pre-update value and leaves new_flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ack   <= 1'b0;
            r_rd_data  <= '0;
            r_new_flag <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rd_ack <= w_accept;
            if (w_accept) begin
                r_rd_data <= r_held;
            end
            if (w_change) begin
                r_new_flag <= 1'b1;
            end else if (w_accept) begin
                r_new_flag <= 1'b0;
            end
            if (w_change && r_new_flag && !w_accept) begin
                r_overrun <= 1'b1;
            end else if (w_accept) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign port_en  = w_port_en;
    assign rd_ack   = r_rd_ack;
    assign rd_data  = r_rd_data;
    assign new_flag = r_new_flag;
    assign overrun  = r_overrun;
    assign irq      = r_new_flag & irq_en;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Scoreboard bench for input_port_ctrl: a cycle-count reference model predicts status
// and read data; a negedge monitor pops and compares.
module tb_input_port_ctrl;
    localparam int WIDTH    = 8;
    localparam int POLL_DIV = 4;
    localparam int PER      = POLL_DIV + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             port_en;
    logic [WIDTH-1:0] port_data;
    logic             rd_req;
    logic             rd_ack;
    logic [WIDTH-1:0] rd_data;
    logic             irq_en;
    logic             irq;
    logic             new_flag;
    logic             overrun;

    input_port_ctrl #(.WIDTH(WIDTH), .POLL_DIV(POLL_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .port_en  (port_en),
        .port_data(port_data),
        .rd_req   (rd_req),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .irq_en   (irq_en),
        .irq      (irq),
        .new_flag (new_flag),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time is the number of edges since reset release.
    int               t = 0;
    logic [WIDTH-1:0] pins = '0;
    logic [WIDTH-1:0] m_held = '0;
    logic [WIDTH-1:0] m_smp = '0;
    logic             m_nf = 1'b0;
    logic             m_ov = 1'b0;
    logic             m_ack = 1'b0;

    // Expected status after each edge: {port_en, rd_ack, new_flag, overrun, irq}
    logic [4:0]       exp_q[$];
    logic [WIDTH-1:0] rd_q[$];

    logic [4:0]       mon_e;
    logic [4:0]       mon_a;
    logic [WIDTH-1:0] mon_d;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {port_en, rd_ack, new_flag, overrun, irq};
            n_vec++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL status t=%0d {en,ack,nf,ov,irq} got %b expected %b", t, mon_a, mon_e);
            end
        end
        if (rd_ack === 1'b1) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_ack t=%0d got ack=1 rd_data=%h expected no acknowledge", t, rd_data);
            end else begin
                mon_d = rd_q.pop_front();
                if (rd_data !== mon_d) begin
                    n_err++;
                    $display("FAIL rd_data t=%0d got %h expected %h", t, rd_data, mon_d);
                end
            end
        end
    end

    task automatic step(input logic req, input logic ien);
        logic acc;
        logic chg;
        rd_req    = req;
        irq_en    = ien;
        // Real pins only during the enable window; garbage elsewhere must be ignored.
        port_data = ((t % PER) == POLL_DIV) ? pins : WIDTH'($urandom);
        @(posedge clk);
        #1;
        acc = req && !m_ack;
        chg = ((t % PER) == POLL_DIV + 2) && (m_smp != m_held);
        if ((t % PER) == POLL_DIV) m_smp = port_data;
        if (acc) rd_q.push_back(m_held);
        m_ov = (chg && m_nf && !acc) ? 1'b1 : (acc ? 1'b0 : m_ov);
        m_nf = chg ? 1'b1 : (acc ? 1'b0 : m_nf);
        if (chg) m_held = m_smp;
        m_ack = acc;
        t++;
        exp_q.push_back({((t % PER) == POLL_DIV), m_ack, m_nf, m_ov, m_nf & ien});
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int phase, input logic ien);
        for (int i = 0; i < PER && (t % PER) != phase; i++) step(1'b0, ien);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({port_en, rd_ack, new_flag, overrun, irq, rd_data} !== '0) begin
            n_err++;
            $display("FAIL async_reset got en=%b ack=%b nf=%b ov=%b irq=%b data=%h expected all 0",
                     port_en, rd_ack, new_flag, overrun, irq, rd_data);
        end
        exp_q.delete();
        rd_q.delete();
        m_held = '0;
        m_smp  = '0;
        m_nf   = 1'b0;
        m_ov   = 1'b0;
        m_ack  = 1'b0;
        rd_req = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        t = 0;
    endtask

    initial begin
        port_data = '0;
        rd_req    = 1'b0;
        irq_en    = 1'b0;
        do_reset();

        // First poll of 0xA5, irq masked and unmasked, then a read
        pins = 8'hA5;
        repeat (PER) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        repeat (PER + 2) step(1'b0, 1'b1);

        // Overrun: 0xA5 then 0x3C with no read in between
        do_reset();
        pins = 8'hA5;
        repeat (PER) step(1'b0, 1'b1);
        pins = 8'h3C;
        repeat (PER) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Read accepted on the same edge as a 0x3C -> 0x81 update
        pins = 8'h81;
        run_to(POLL_DIV + 2, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Continuous request
        repeat (6) step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Reset while in SYNC, then reset while rd_ack is high
        run_to(POLL_DIV + 1, 1'b1);
        do_reset();
        repeat (PER + 1) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        do_reset();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ((t % PER) == 0 && $urandom_range(0, 1) == 0) pins = WIDTH'($urandom);
            step($urandom_range(0, 2) == 0, 1'($urandom));
        end

        n_vec++;
        if (rd_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_reads got %0d unacknowledged expected 0", rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
